ads127l_tdm_capture: RTL

Parametrised capture engine for ADS127L18-family serial data outputs. Oversamples DCLK, FSYNC and up to 8 DOUT lanes in the system clock domain, deserialises TDM frames of several channels per lane, and buffers each complete frame. Drains the frame as an AXI-Stream-style channel-tagged sample stream, with status counters. Sits in fpga_core between the ADC pins and the UDP payload packer; replaces fixed 8-lane / 24-bit / 1-slot capture.

---
 rtl/ads127l_pkg.sv | 22 ++
 rtl/ads127l_pin_sync.sv | 66 ++++++
 rtl/ads127l_tdm_capture.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ads127l_pkg.sv
// Shared types and derived-geometry helpers for the ADS127L TDM capture path.
package ads127l_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cap_state_e;

    function automatic int frame_bits(input int bits_per_sample, input int ch_per_lane);
        return bits_per_sample * ch_per_lane;
    endfunction

    function automatic int total_ch(input int lane_count, input int ch_per_lane);
        return lane_count * ch_per_lane;
    endfunction

    function automatic int chan_index(input int lane, input int slot, input int ch_per_lane);
        return lane * ch_per_lane + slot;
    endfunction

endpackage

// File: rtl/ads127l_pin_sync.sv
// Synchronises dclk/fsync/dout and flags DCLK rising edges with aligned data.
// Outputs are registered one cycle after the synchroniser; no backpressure.
module ads127l_pin_sync #(
    parameter int LANE_COUNT  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dclk,
    input  logic                  fsync,
    input  logic [LANE_COUNT-1:0] dout,
    output logic                  dclk_rise,
    output logic                  fsync_edge,
    output logic [LANE_COUNT-1:0] dout_smp
);

    localparam int W = LANE_COUNT + 2;

    logic [W-1:0]          sync_q [SYNC_STAGES];
    logic [W-1:0]          sync_d [SYNC_STAGES];
    logic [W-1:0]          pins_s;
    logic                  dclk_prev_q, dclk_prev_d;
    logic                  fsync_prev_q, fsync_prev_d;
    logic                  rise_q, rise_d;
    logic                  fsync_edge_q, fsync_edge_d;
    logic [LANE_COUNT-1:0] dout_smp_q, dout_smp_d;

    always_comb begin
        sync_d[0] = {fsync, dclk, dout};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        pins_s       = sync_q[SYNC_STAGES-1];
        dclk_prev_d  = pins_s[LANE_COUNT];
        rise_d       = pins_s[LANE_COUNT] & ~dclk_prev_q;
        // FSYNC history only advances on DCLK edges so a held-high FSYNC counts once.
        fsync_prev_d = rise_d ? pins_s[LANE_COUNT+1] : fsync_prev_q;
        fsync_edge_d = rise_d & pins_s[LANE_COUNT+1] & ~fsync_prev_q;
        dout_smp_d   = pins_s[LANE_COUNT-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dclk_prev_q  <= 1'b0;
            fsync_prev_q <= 1'b0;
            rise_q       <= 1'b0;
            fsync_edge_q <= 1'b0;
            dout_smp_q   <= '0;
        end else begin
            sync_q       <= sync_d;
            dclk_prev_q  <= dclk_prev_d;
            fsync_prev_q <= fsync_prev_d;
            rise_q       <= rise_d;
            fsync_edge_q <= fsync_edge_d;
            dout_smp_q   <= dout_smp_d;
        end
    end

    assign dclk_rise  = rise_q;
    assign fsync_edge = fsync_edge_q;
    assign dout_smp   = dout_smp_q;

endmodule

// File: rtl/ads127l_tdm_capture.sv
// Deserialises ADS127L TDM frames into a one-frame buffer drained as a tagged sample stream.
// Last DCLK pin edge to m_tvalid: SYNC_STAGES+3 cycles; frames arriving while the buffer is held are dropped.
module ads127l_tdm_capture
    import ads127l_pkg::*;
#(
    parameter int LANE_COUNT      = 8,
    parameter int BITS_PER_SAMPLE = 24,
    parameter int CH_PER_LANE     = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       dclk,
    input  logic                       fsync,
    input  logic [LANE_COUNT-1:0]      dout,
    output logic [BITS_PER_SAMPLE-1:0] m_tdata,
    output logic [7:0]                 m_tchan,
    output logic                       m_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       frame_strobe,
    output logic [CNT_WIDTH-1:0]       frame_count,
    output logic [CNT_WIDTH-1:0]       overrun_count,
    output logic [CNT_WIDTH-1:0]       sync_err_count
);

    localparam int F      = frame_bits(BITS_PER_SAMPLE, CH_PER_LANE);
    localparam int NCH    = total_ch(LANE_COUNT, CH_PER_LANE);
    localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_BW = $clog2(F + 1);
    localparam logic [CNT_BW-1:0]    LAST_BIT = CNT_BW'(F - 1);
    localparam logic [IDX_W-1:0]     LAST_CH  = IDX_W'(NCH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic                  dclk_rise, fsync_edge;
    logic [LANE_COUNT-1:0] dout_smp;

    cap_state_e                 state_q, state_d;
    logic [CNT_BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [F-1:0]               shreg_q [LANE_COUNT];
    logic [F-1:0]               shreg_d [LANE_COUNT];
    logic [BITS_PER_SAMPLE-1:0] sample_q [2**IDX_W];
    logic [BITS_PER_SAMPLE-1:0] sample_d [2**IDX_W];
    logic                       buf_full_q, buf_full_d;
    logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
    logic                       frame_strobe_q, frame_strobe_d;
    logic [CNT_WIDTH-1:0]       frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0]       overrun_count_q, overrun_count_d;
    logic [CNT_WIDTH-1:0]       sync_err_count_q, sync_err_count_d;

    ads127l_pin_sync #(
        .LANE_COUNT (LANE_COUNT),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .dclk      (dclk),
        .fsync     (fsync),
        .dout      (dout),
        .dclk_rise (dclk_rise),
        .fsync_edge(fsync_edge),
        .dout_smp  (dout_smp)
    );

    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        shreg_d          = shreg_q;
        sample_d         = sample_q;
        buf_full_d       = buf_full_q;
        rd_idx_d         = rd_idx_q;
        frame_strobe_d   = 1'b0;
        frame_count_d    = frame_count_q;
        overrun_count_d  = overrun_count_q;
        sync_err_count_d = sync_err_count_q;

        if (buf_full_q && m_tready) begin
            if (rd_idx_q == LAST_CH) begin
                buf_full_d = 1'b0;
                rd_idx_d   = '0;
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end

        // Stale bits from an aborted frame are pushed out by the F shifts of the next one.
        if (dclk_rise) begin
            for (int l = 0; l < LANE_COUNT; l++) begin
                shreg_d[l] = {shreg_q[l][F-2:0], dout_smp[l]};
            end
        end

        if (!enable) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (dclk_rise && fsync_edge) begin
                        bit_cnt_d = CNT_BW'(1);
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (dclk_rise) begin
                        if (fsync_edge) begin
                            bit_cnt_d = CNT_BW'(1);
                            if (sync_err_count_q != CNT_MAX) begin
                                sync_err_count_d = sync_err_count_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_BW'(1);
                            if (bit_cnt_q == LAST_BIT) begin
                                state_d = COMMIT;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state_d = HUNT;
                    if (!buf_full_q) begin
                        for (int l = 0; l < LANE_COUNT; l++) begin
                            for (int s = 0; s < CH_PER_LANE; s++) begin
                                sample_d[chan_index(l, s, CH_PER_LANE)] =
                                    shreg_q[l][F-1-s*BITS_PER_SAMPLE -: BITS_PER_SAMPLE];
                            end
                        end
                        buf_full_d     = 1'b1;
                        rd_idx_d       = '0;
                        frame_strobe_d = 1'b1;
                        frame_count_d  = frame_count_q + CNT_WIDTH'(1);
                    end else if (overrun_count_q != CNT_MAX) begin
                        overrun_count_d = overrun_count_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            for (int l = 0; l < LANE_COUNT; l++) begin
                shreg_q[l] <= '0;
            end
            for (int c = 0; c < 2**IDX_W; c++) begin
                sample_q[c] <= '0;
            end
            buf_full_q       <= 1'b0;
            rd_idx_q         <= '0;
            frame_strobe_q   <= 1'b0;
            frame_count_q    <= '0;
            overrun_count_q  <= '0;
            sync_err_count_q <= '0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            shreg_q          <= shreg_d;
            sample_q         <= sample_d;
            buf_full_q       <= buf_full_d;
            rd_idx_q         <= rd_idx_d;
            frame_strobe_q   <= frame_strobe_d;
            frame_count_q    <= frame_count_d;
            overrun_count_q  <= overrun_count_d;
            sync_err_count_q <= sync_err_count_d;
        end
    end

    assign m_tvalid       = buf_full_q;
    assign m_tdata        = sample_q[rd_idx_q];
    assign m_tchan        = 8'(rd_idx_q);
    assign m_tlast        = buf_full_q && (rd_idx_q == LAST_CH);
    assign frame_strobe   = frame_strobe_q;
    assign frame_count    = frame_count_q;
    assign overrun_count  = overrun_count_q;
    assign sync_err_count = sync_err_count_q;

endmodule
